// File: rtl/somador_serial.sv
// somador_serial: bit-serial N-bit unsigned adder, LSB first, one bit per clock.
// A start pulse captures a, b and cin. After N processing edges the sum and
// carry-out are published on s/cout together with a one-cycle pronto pulse.
// Optional macro SOMADOR_SERIAL_OVERFLOW_EN adds a registered signed-overflow
// flag (ovf); with the macro undefined the port and its logic do not exist.
module somador_serial #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         pronto,
  output logic         ocupado
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  // The counter must be able to hold N-1, the value on the final processing edge
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] SOMANDO = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_shA;
  logic [N-1:0]  r_shB;
  logic [N-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_s;
  logic          r_cout;
  logic          r_pronto;

  logic          w_sumBit;
  logic          w_carryNext;
  logic [N-1:0]  w_resNext;
  logic          w_start;
  logic          w_finish;

  // One-bit full adder working on the current LSBs and the registered carry
  assign w_sumBit    = r_shA[0] ^ r_shB[0] ^ r_carry;
  assign w_carryNext = (r_shA[0] & r_shB[0]) | (r_carry & (r_shA[0] ^ r_shB[0]));

  // Start is honoured only when idle or in the single done cycle
  assign w_start  = inicio && ((r_state == OCIOSO) || (r_state == FIM));
  assign w_finish = (r_state == SOMANDO) && (r_cnt == LAST);

  // Each new sum bit enters at the MSB so that after N shifts the LSB sits at bit 0
  generate
    if (N == 1) begin : g_resOne
      assign w_resNext = w_sumBit;
    end else begin : g_resMany
      assign w_resNext = {w_sumBit, r_res[N-1:1]};
    end
  endgenerate

  // Sequencing and serial datapath: load on start, shift once per edge while adding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCIOSO;
      r_shA   <= '0;
      r_shB   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        OCIOSO, FIM: begin
          if (w_start) begin
            r_shA   <= a;
            r_shB   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= SOMANDO;
          end else begin
            r_state <= OCIOSO;
          end
        end
        SOMANDO: begin
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_carry <= w_carryNext;
          r_res   <= w_resNext;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= FIM;
          end
        end
        default: begin
          r_state <= OCIOSO;
        end
      endcase
    end
  end

  // Published result: only the completion edge or reset may change s/cout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_pronto <= 1'b0;
    end else begin
      r_pronto <= w_finish;
      if (w_finish) begin
        r_s    <= w_resNext;
        r_cout <= w_carryNext;
      end
    end
  end

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow: on the last edge r_carry is the carry into the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_finish) begin
      r_ovf <= r_carry ^ w_carryNext;
    end
  end

  assign ovf = r_ovf;
`endif

  assign s       = r_s;
  assign cout    = r_cout;
  assign pronto  = r_pronto;
  assign ocupado = (r_state == SOMANDO);

endmodule

// File: tb/tb_somador_serial.sv
// Testbench for somador_serial with two instances (N=2 and N=4), checked
// against an arithmetic reference model: {cout,s} = a + b + cin.
// Define SOMADOR_SERIAL_OVERFLOW_EN to also check the ovf flag.
module tb_somador_serial;

  logic clk;
  logic rst2, inicio2, cin2;
  logic [1:0] a2, b2, s2;
  logic cout2, pronto2, ocupado2;
  logic rst4, inicio4, cin4;
  logic [3:0] a4, b4, s4;
  logic cout4, pronto4, ocupado4;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  logic ovf2, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  somador_serial #(.N(2)) dut2 (
    .clk(clk), .rst(rst2), .inicio(inicio2), .a(a2), .b(b2), .cin(cin2),
    .s(s2), .cout(cout2), .pronto(pronto2), .ocupado(ocupado2)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  somador_serial #(.N(4)) dut4 (
    .clk(clk), .rst(rst4), .inicio(inicio4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .pronto(pronto4), .ocupado(ocupado4)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two's-complement overflow from signed arithmetic on the operands
  function automatic logic ovfModel(input int ia, input int ib, input int ic, input int w);
    int sa, sb, r;
    sa = (ia >= (1 << (w - 1))) ? ia - (1 << w) : ia;
    sb = (ib >= (1 << (w - 1))) ? ib - (1 << w) : ib;
    r  = sa + sb + ic;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  // Launch one N=2 operation, scramble operands after acceptance, wait for pronto
  task automatic doOp2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                       output logic [1:0] os, output logic oc, output logic oovf,
                       output int lat, output int changes);
    logic [1:0] prevS;
    prevS = s2;
    a2 = ia; b2 = ib; cin2 = ic; inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    lat = 0; changes = 0;
    while (!pronto2 && lat < 20) begin
      if (s2 !== prevS) changes++;
      tick();
      lat++;
    end
    os = s2; oc = cout2;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    oovf = ovf2;
`else
    oovf = 1'b0;
`endif
  endtask

  // Same as doOp2 for the N=4 instance
  task automatic doOp4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                       output logic [3:0] os, output logic oc, output logic oovf,
                       output int lat, output int changes);
    logic [3:0] prevS;
    prevS = s4;
    a4 = ia; b4 = ib; cin4 = ic; inicio4 = 1'b1;
    tick();
    inicio4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0; changes = 0;
    while (!pronto4 && lat < 20) begin
      if (s4 !== prevS) changes++;
      tick();
      lat++;
    end
    os = s4; oc = cout4;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    oovf = ovf4;
`else
    oovf = 1'b0;
`endif
  endtask

  // Reset both instances, then idle ten cycles with all outputs at zero
  task automatic test_reset;
    int bad;
    rst2 = 1'b1; rst4 = 1'b1; inicio2 = 1'b0; inicio4 = 1'b0;
    a2 = '0; b2 = '0; cin2 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick(); tick();
    rst2 = 1'b0; rst4 = 1'b0;
    checks++;
    if ({s2, cout2, pronto2, ocupado2} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset2: got s=%b cout=%b pronto=%b ocupado=%b expected all 0", s2, cout2, pronto2, ocupado2);
    end
    checks++;
    if ({s4, cout4, pronto4, ocupado4} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset4: got s=%b cout=%b pronto=%b ocupado=%b expected all 0", s4, cout4, pronto4, ocupado4);
    end
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    checks++;
    if ({ovf2, ovf4} !== 2'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b%b expected 00", ovf2, ovf4);
    end
`endif
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom);
      tick();
      if ({s2, cout2, pronto2, ocupado2} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got %0d changed cycles expected 0", bad);
    end
  endtask

  // 11 + 01 + 0 with a cycle-by-cycle look at ocupado/pronto
  task automatic test_basic;
    a2 = 2'b11; b2 = 2'b01; cin2 = 1'b0; inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0;
    checks++;
    if ({ocupado2, pronto2} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL basic_k: got ocupado=%b pronto=%b expected 1 0", ocupado2, pronto2);
    end
    tick();
    checks++;
    if ({ocupado2, pronto2, s2, cout2} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL basic_k1: got ocupado=%b pronto=%b s=%b cout=%b expected 1 0 00 0", ocupado2, pronto2, s2, cout2);
    end
    tick();
    checks++;
    if ({ocupado2, pronto2, s2, cout2} !== 5'b01001) begin
      errors++;
      $display("[TB] FAIL basic_k2: got ocupado=%b pronto=%b s=%b cout=%b expected 0 1 00 1", ocupado2, pronto2, s2, cout2);
    end
    tick();
    checks++;
    if ({ocupado2, pronto2, s2, cout2} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL basic_k3: got ocupado=%b pronto=%b s=%b cout=%b expected 0 0 00 1", ocupado2, pronto2, s2, cout2);
    end
  endtask

  // Second operation started in the FIM cycle is accepted immediately
  task automatic test_back_to_back;
    logic [1:0] os; logic oc, oo; int lat, ch;
    doOp2(2'b10, 2'b01, 1'b1, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os} !== 3'b100 || lat != 2) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %b%b lat=%0d expected 100 lat=2", oc, os, lat);
    end
    doOp2(2'b01, 2'b01, 1'b0, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os} !== 3'b010 || lat != 2) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %b%b lat=%0d expected 010 lat=2", oc, os, lat);
    end
    tick();
  endtask

  // inicio held high during SOMANDO must be ignored until FIM
  task automatic test_start_busy;
    int lat;
    a2 = 2'b01; b2 = 2'b01; cin2 = 1'b0; inicio2 = 1'b1;
    tick();
    a2 = 2'b11; b2 = 2'b11;
    lat = 0;
    while (!pronto2 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if ({cout2, s2} !== 3'b010 || lat != 2) begin
      errors++;
      $display("[TB] FAIL busy_first: got %b%b lat=%0d expected 010 lat=2", cout2, s2, lat);
    end
    tick();
    inicio2 = 1'b0;
    checks++;
    if ({ocupado2, pronto2} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL busy_accept: got ocupado=%b pronto=%b expected 1 0", ocupado2, pronto2);
    end
    lat = 0;
    while (!pronto2 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if ({cout2, s2} !== 3'b110 || lat != 2) begin
      errors++;
      $display("[TB] FAIL busy_second: got %b%b lat=%0d expected 110 lat=2", cout2, s2, lat);
    end
    tick();
  endtask

  // Reset at the second processing edge discards the operation
  task automatic test_reset_mid;
    logic [3:0] os; logic oc, oo; int lat, ch, seen;
    doOp4(4'b0101, 4'b0010, 1'b0, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os} !== 5'b00111 || lat != 4) begin
      errors++;
      $display("[TB] FAIL mid_pre: got %b%b lat=%0d expected 00111 lat=4", oc, os, lat);
    end
    tick();
    a4 = 4'b1111; b4 = 4'b0001; cin4 = 1'b0; inicio4 = 1'b1;
    tick();
    inicio4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    checks++;
    if ({s4, cout4, pronto4, ocupado4} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got s=%b cout=%b pronto=%b ocupado=%b expected all 0", s4, cout4, pronto4, ocupado4);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pronto4 || ocupado4 || s4 !== 4'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL mid_quiet: got %0d active cycles expected 0", seen);
    end
    doOp4(4'b0011, 4'b0100, 1'b0, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os} !== 5'b00111 || lat != 4) begin
      errors++;
      $display("[TB] FAIL mid_fresh: got %b%b lat=%0d expected 00111 lat=4", oc, os, lat);
    end
    tick();
  endtask

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  // Signed overflow flag on the two reference vectors
  task automatic test_overflow;
    logic [1:0] os; logic oc, oo; int lat, ch;
    doOp2(2'b01, 2'b01, 1'b0, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os, oo} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL ovf_pos: got cout=%b s=%b ovf=%b expected 0 10 1", oc, os, oo);
    end
    doOp2(2'b11, 2'b11, 1'b0, os, oc, oo, lat, ch);
    checks++;
    if ({oc, os, oo} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL ovf_neg: got cout=%b s=%b ovf=%b expected 1 10 0", oc, os, oo);
    end
    tick();
  endtask
`endif

  // Random operands on both widths, random idle gaps (zero gap = back-to-back)
  task automatic test_random;
    logic [1:0] os2; logic [3:0] os4; logic oc, oo; int lat, ch, gap;
    int ia, ib, ic, sum;
    for (int n = 0; n < 25; n++) begin
      ia = $urandom_range(0, 3); ib = $urandom_range(0, 3); ic = $urandom_range(0, 1);
      sum = ia + ib + ic;
      doOp2(2'(ia), 2'(ib), 1'(ic), os2, oc, oo, lat, ch);
      checks++;
      if ({oc, os2} !== 3'(sum) || lat != 2 || ch != 0) begin
        errors++;
        $display("[TB] FAIL rand2: %0d+%0d+%0d got %b%b lat=%0d chg=%0d expected %b lat=2 chg=0", ia, ib, ic, oc, os2, lat, ch, 3'(sum));
      end
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      checks++;
      if (oo !== ovfModel(ia, ib, ic, 2)) begin
        errors++;
        $display("[TB] FAIL rand2_ovf: %0d+%0d+%0d got %b expected %b", ia, ib, ic, oo, ovfModel(ia, ib, ic, 2));
      end
`endif
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        for (int g = 0; g < gap; g++) tick();
        checks++;
        if ({cout2, s2} !== 3'(sum) || pronto2 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand2_hold: got %b%b pronto=%b expected %b pronto=0", cout2, s2, pronto2, 3'(sum));
        end
      end
    end
    for (int n = 0; n < 20; n++) begin
      ia = $urandom_range(0, 15); ib = $urandom_range(0, 15); ic = $urandom_range(0, 1);
      sum = ia + ib + ic;
      doOp4(4'(ia), 4'(ib), 1'(ic), os4, oc, oo, lat, ch);
      checks++;
      if ({oc, os4} !== 5'(sum) || lat != 4 || ch != 0) begin
        errors++;
        $display("[TB] FAIL rand4: %0d+%0d+%0d got %b%b lat=%0d chg=%0d expected %b lat=4 chg=0", ia, ib, ic, oc, os4, lat, ch, 5'(sum));
      end
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      checks++;
      if (oo !== ovfModel(ia, ib, ic, 4)) begin
        errors++;
        $display("[TB] FAIL rand4_ovf: %0d+%0d+%0d got %b expected %b", ia, ib, ic, oo, ovfModel(ia, ib, ic, 4));
      end
`endif
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
